// File: rtl/md5_iter_core.sv
// rtl/md5_iter_core.sv - iterative MD5 compression core with multi-block chaining
// Runs ROUNDS_PER_CYCLE chained steps per clock over a latched 512-bit block.
module md5_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic [127:0] digest,
    output logic         digest_valid
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("md5_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [3:0][31:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [6:0] LAST_I = 7'(64 - ROUNDS_PER_CYCLE);

    localparam logic [0:15][4:0] S_TAB = {
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21};

    localparam logic [0:63][31:0] T_TAB = {
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

    state_t            state_q, state_d;
    logic [3:0][31:0]  h_q;
    logic [31:0]       m_q [16];
    logic [31:0]       a_q, b_q, c_q, d_q;
    logic [31:0]       sa, sb, sc, sd;
    logic [6:0]        i_q;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (blk_valid) state_d = S_RUN;
            S_RUN:   if (i_q == LAST_I) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blk_ready = (state_q == S_IDLE);
    end

    assign accept = blk_valid & blk_ready;

    // Chain R steps combinationally; i_q is always a multiple of R inside RUN.
    always_comb begin : step_chain
        logic [31:0] f, sum, rot;
        logic [5:0]  idx;
        logic [3:0]  g;
        logic [4:0]  s;
        sa = a_q; sb = b_q; sc = c_q; sd = d_q;
        f = '0; sum = '0; rot = '0; idx = '0; g = '0; s = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            idx = i_q[5:0] + 6'(k);
            case (idx[5:4])
                2'd0: begin f = (sb & sc) | (~sb & sd); g = idx[3:0];     end
                2'd1: begin f = (sb & sd) | (sc & ~sd); g = 4'(5*idx + 1); end
                2'd2: begin f = sb ^ sc ^ sd;          g = 4'(3*idx + 5); end
                default: begin f = sc ^ (sb | ~sd);    g = 4'(7*idx);     end
            endcase
            s   = S_TAB[{idx[5:4], idx[1:0]}];
            sum = sa + f + m_q[g] + T_TAB[idx];
            rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
            sa  = sd;
            sd  = sc;
            sc  = sb;
            sb  = sb + rot;
        end
    end

    // Working registers, block buffer and step counter carry no reset: they are
    // reloaded on every accept and never reach the outputs directly.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < 16; j++) m_q[j] <= blk_data[32*j +: 32];
            a_q <= init ? IV[0] : h_q[0];
            b_q <= init ? IV[1] : h_q[1];
            c_q <= init ? IV[2] : h_q[2];
            d_q <= init ? IV[3] : h_q[3];
            i_q <= '0;
        end else if (state_q == S_RUN) begin
            a_q <= sa;
            b_q <= sb;
            c_q <= sc;
            d_q <= sd;
            i_q <= i_q + 7'(ROUNDS_PER_CYCLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q          <= IV;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            if (accept && init) h_q <= IV;
            if (state_q == S_FINAL) begin
                h_q[0]       <= h_q[0] + a_q;
                h_q[1]       <= h_q[1] + b_q;
                h_q[2]       <= h_q[2] + c_q;
                h_q[3]       <= h_q[3] + d_q;
                digest       <= {h_q[3] + d_q, h_q[2] + c_q, h_q[1] + b_q, h_q[0] + a_q};
                digest_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md5_iter_core.sv
// tb/tb_md5_iter_core.sv - directed bench for md5_iter_core with an MD5 reference model
module tb_md5_iter_core;

    localparam logic [127:0] IV_H   = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] D_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] D_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
    localparam logic [511:0] B_EMPTY = 512'h80;
    localparam logic [511:0] B_ABC   = (512'h18 << 448) | 512'h80636261;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic [127:0] digest;
    logic         digest_valid;

    logic         sw_init = 1'b0;
    logic         sw_valid = 1'b0;
    logic [511:0] sw_data = '0;
    logic         sw_rdy [4];
    logic [127:0] sw_dig [4];
    logic         sw_vld [4];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_edge = 0;
    int idle_from = 0;
    int vld_edge = -1;
    logic [127:0] hm = IV_H;
    logic [127:0] exp_dig = '0;
    logic [127:0] pend_dig = '0;
    logic [31:0]  tk [64];

    always #5 clk = ~clk;

    md5_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .digest(digest),
        .digest_valid(digest_valid));

    for (genvar k = 0; k < 4; k++) begin : g_sweep
        md5_iter_core #(.ROUNDS_PER_CYCLE(2 << k)) u_sw (
            .clk(clk), .rst_n(rst_n), .init(sw_init), .blk_valid(sw_valid),
            .blk_ready(sw_rdy[k]), .blk_data(sw_data), .digest(sw_dig[k]),
            .digest_valid(sw_vld[k]));
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int sh_amt(int i);
        int tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        return tab[(i / 16) * 4 + i % 4];
    endfunction

    // Straight MD5 compression of one block from chaining value h.
    function automatic logic [127:0] md5_blk(logic [127:0] h, logic [511:0] m);
        logic [31:0] a, b, c, d, f, x, t;
        logic [63:0] xx;
        int g;
        a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i;                end
                1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16;     end
            endcase
            x  = a + f + m[32*g +: 32] + tk[i];
            xx = {x, x} >> (32 - sh_amt(i));
            t  = d;
            d  = c;
            c  = b;
            b  = b + xx[31:0];
            a  = t;
        end
        return {h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    endfunction

    // Model: decides acceptance from spec-level readiness and schedules the digest.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            hm = IV_H; idle_from = cyc; vld_edge = -1; exp_dig = '0;
        end else begin
            if (cyc == vld_edge) exp_dig = pend_dig;
            if (blk_valid && (cyc - 1 >= idle_from)) begin
                pend_dig  = md5_blk(init ? IV_H : hm, blk_data);
                hm        = pend_dig;
                vld_edge  = cyc + 65;
                idle_from = cyc + 65;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_digest", digest, '0);
            chk("rst_valid", 128'(digest_valid), '0);
        end else begin
            chk("ready", 128'(blk_ready), 128'(cyc >= idle_from));
            chk("valid", 128'(digest_valid), 128'(cyc == vld_edge));
            chk("digest", digest, exp_dig);
        end
    end

    task automatic send(input logic i_init, input logic [511:0] d);
        int n = 0;
        @(negedge clk);
        while (!blk_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL send_timeout actual=not_ready expected=ready");
        end
        blk_valid = 1'b1; init = i_init; blk_data = d;
        @(posedge clk);
        #1 acc_edge = cyc;
        @(negedge clk);
        blk_valid = 1'b0; init = 1'b0;
    endtask

    task automatic wait_digest(output logic [127:0] d, output int lat);
        int n = 0;
        d = '0; lat = -1;
        while (n < 300) begin
            if (digest_valid) begin
                d = digest; lat = cyc - acc_edge;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL wait_digest actual=timeout expected=pulse");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int lat;
        for (int i = 0; i < 64; i++) begin
            real r;
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            tk[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        chk("t_first", 128'(tk[0]), 128'(32'hd76aa478));
        chk("t_last", 128'(tk[63]), 128'(32'heb86d391));
        chk("model_empty", md5_blk(IV_H, B_EMPTY), D_EMPTY);
        chk("model_abc", md5_blk(IV_H, B_ABC), D_ABC);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 128'(blk_ready), 128'(1));

        // Latency sweep for R = 2, 4, 8, 16 on the "abc" block
        sw_valid = 1'b1; sw_init = 1'b1; sw_data = B_ABC;
        @(negedge clk);
        sw_valid = 1'b0; sw_init = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sweep_valid_r%0d_n%0d", 2 << k, n), 128'(sw_vld[k]),
                    128'(n == 64 / (2 << k) + 1));
                if (n == 64 / (2 << k) + 1)
                    chk($sformatf("sweep_digest_r%0d", 2 << k), sw_dig[k], D_ABC);
            end
        end

        send(1'b1, B_EMPTY);
        wait_digest(d, lat);
        chk("empty_lat", 128'(lat), 128'(65));
        chk("empty_digest", d, D_EMPTY);

        // Backpressure with churning inputs, then chained empty block on the pulse cycle
        send(1'b1, B_ABC);
        for (int n = 0; n < 64; n++) begin
            blk_valid = 1'b1;
            init = 1'($urandom);
            blk_data = {16{$urandom}};
            @(negedge clk);
        end
        blk_valid = 1'b1; init = 1'b0; blk_data = B_EMPTY;
        @(negedge clk);
        chk("bp_valid", 128'(digest_valid), 128'(1));
        chk("bp_ready_on_pulse", 128'(blk_ready), 128'(1));
        chk("bp_digest", digest, D_ABC);
        @(posedge clk);
        #1 acc_edge = cyc;
        @(negedge clk);
        blk_valid = 1'b0;
        wait_digest(d, lat);
        chk("chain_lat", 128'(lat), 128'(65));
        chk("chain_differs", 128'(d != D_EMPTY), 128'(1));
        chk("chain_model", d, md5_blk(D_ABC, B_EMPTY));

        send(1'b1, B_ABC);
        wait_digest(d, lat);
        chk("abc_lat", 128'(lat), 128'(65));
        chk("abc_digest", d, D_ABC);

        // Reset partway through a chained block, then "abc" without init
        send(1'b0, B_EMPTY);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_digest", digest, '0);
        #2 rst_n = 1'b1;
        send(1'b0, B_ABC);
        wait_digest(d, lat);
        chk("post_rst_lat", 128'(lat), 128'(65));
        chk("post_rst_digest", d, D_ABC);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md5_iter_core.md
# md5_iter_core

Iterative MD5 compression engine. It accepts one pre-padded 512-bit message block per handshake and runs the 64 MD5 steps at `ROUNDS_PER_CYCLE` steps per clock. It keeps the 128-bit chaining state across blocks and presents the updated digest with a one-cycle valid pulse. It is the sequential, parametrised successor of the single-step round datapath: it wraps step logic with block buffering, step counting and multi-block chaining, and sits between the message padder and the digest consumer.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: MD5 steps per clock. Legal values are 1, 2, 4, 8, 16. Any other value is a elaboration-time error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init`  in  1  when set together with an accepted block, the block starts from the MD5 IV instead of the chaining state.
- `blk_valid`  in  1  `blk_data` is valid.
- `blk_ready`  out  1  core can accept a block; high only in IDLE.
- `blk_data`  in  512  padded block. Word j is `M[j] = blk_data[32j+31:32j]`, little-endian bytes, so message byte 0 sits in bits 7:0.
- `digest`  out  128  `{H3,H2,H1,H0}`, with H0 in bits 31:0.
- `digest_valid`  out  1  one-cycle pulse when `digest` is updated.

## Operation
- States and transitions:
  - IDLE: on `blk_valid & blk_ready`, go to RUN.
  - RUN: after the last step group, go to FINAL.
  - FINAL: go to IDLE.
- Accept edge:
  - Latch `M[0..15]`.
  - Load working regs a,b,c,d from (`init` ? IV : H0..H3).
  - If `init`, also load H0..H3 with the IV.
  - Clear step counter i to 0.
- IV: H0=0x67452301, H1=0xefcdab89, H2=0x98badcfe, H3=0x10325476.
- Each RUN edge applies `ROUNDS_PER_CYCLE` chained steps, i..i+R-1, then adds R to i.
- Step i:
  - Round selection by i/16:
    - 0: F=(b&c)|(~b&d), g=i
    - 1: G=(b&d)|(c&~d), g=(5i+1) mod 16
    - 2: H=b^c^d, g=(3i+5) mod 16
    - 3: I=c^(b|~d), g=7i mod 16
  - sum = a + f + M[g] + T[i], all mod 2^32.
  - T[i] = floor(abs(sin(i+1))·2^32).
  - Rotate: b' = b + rotl32(sum, s[i]). The rotate must be a true rotate (`<<s | >>(32-s)`) applied before the add to b.
  - Shift amounts s per round: {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}, each cycled four times.
  - Register update: (a,b,c,d) ← (d, b', b, c).
- RUN ends when i reaches 64.
- FINAL edge:
  - Hk ← Hk + working reg, mod 2^32, pairing H0+a, H1+b, H2+c, H3+d.
  - `digest` ← new {H3..H0}.
  - `digest_valid` ← 1.
- Chaining: the next block accepted without `init` continues from the updated H.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE
  - H = IV
  - `digest` = 0
  - `digest_valid` = 0
  - `blk_ready` = 1 after reset release
  - a..d, M and i are don't-care, but must not be visible on outputs.
- Latency: handshake at edge 0. RUN covers edges 1..64/R. FINAL is edge 64/R+1, where `digest_valid` rises. Latency is 65 edges for R=1 and 5 for R=16.
- Throughput: one block per 64/R+2 cycles.
  - `blk_ready` is 0 in RUN and FINAL.
  - It is 1 in the same cycle `digest_valid` is 1, so back-to-back accept is allowed on the pulse cycle.
- `digest_valid` is high for exactly one cycle per block. `digest` holds its value until the next FINAL.
- `blk_valid`, `blk_data` and `init` are ignored while `blk_ready`=0. There is no queuing.
- `init`=1 with `blk_valid`=0 has no effect.
- Reset mid-RUN or mid-FINAL:
  - The block is abandoned and no `digest_valid` is produced.
  - H returns to IV.
- Counter i must not wrap past 64. There is no extra step at the boundary.

## Test plan
- Empty message, R=1: `init`=1, M[0]=0x00000080, all other words 0.
  - `digest_valid` is at edge 65.
  - `digest` = {0x7e42f8ec, 0x980980e9, 0x04b2008f, 0xd98c1dd4}, i.e. hex d41d8cd98f00b204e9800998ecf8427e.
- "abc", swept over R=1, 2, 4, 8, 16: `init`=1, M[0]=0x80636261, M[14]=0x18.
  - `digest` = {0x727fe128, 0x7d3f96d6, 0xb04fd23c, 0x98500190} for every R.
  - Valid lands at edges 65, 33, 17, 9 and 5 respectively.
- Chaining: "abc" block with `init`=1, then the empty-message block with `init`=0, accepted on the pulse cycle.
  - The second digest matches the reference model seeded with the first H.
  - It differs from d41d8cd9….
  - A third block sent with `init`=1 reproduces the standalone value.
- Backpressure: hold `blk_valid`=1 with changing `blk_data` through RUN.
  - `blk_ready`=0 throughout, and exactly one block is processed.
  - The second accept happens only on the `digest_valid` cycle.
- Reset mid-operation: assert `rst_n`=0 at step 30, release, then send "abc" with `init`=0.
  - No stray `digest_valid`, and `digest` reads 0 during reset.
  - The result equals the "abc" digest, proving H returned to the IV.
